// File: rtl/demorgan_checker.sv
// Response checker for the demorgan block: recomputes expected outputs per accepted vector,
// counts vectors and mismatches, tracks input coverage and latches the first failing vector.
module demorgan_checker #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MIN_VECS    = 4,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic [7:0]       dut_out,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       coverage,
  output logic             first_err_valid,
  output logic [9:0]       first_err_vec,
  output logic [7:0]       first_err_mask,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic clear;
  logic accept;

  // Stage 1: captured vector
  logic       s1_valid_q;
  logic [9:0] s1_vec_q;
  logic [7:0] s1_exp;
  logic [7:0] s1_mask;
  logic       s1_a, s1_b;

  // Stage 2: vector plus mismatch mask, consumed by the result registers
  logic       s2_valid_q;
  logic [9:0] s2_vec_q;
  logic [7:0] s2_mask_q;

  logic [CNT_W-1:0] vec_count_q, err_count_q;
  logic [3:0]       coverage_q;
  logic             first_err_valid_q;
  logic [9:0]       first_err_vec_q;
  logic [7:0]       first_err_mask_q;

  // Accept-side bookkeeping so completion can be decided on the accepting cycle,
  // ahead of the result registers that lag by the pipeline depth.
  logic [CNT_W-1:0] acc_cnt_q;
  logic [3:0]       acc_cov_q;
  logic [3:0]       cur_onehot;
  logic [31:0]      acc_next;
  logic             complete_cov;
  logic             stop_hit;

  assign clear  = reset | restart;
  assign accept = in_valid & in_ready;

  assign s1_a    = s1_vec_q[9];
  assign s1_b    = s1_vec_q[8];
  assign s1_exp  = {~s1_a, ~s1_b, ~s1_a & ~s1_b, s1_a | s1_b,
                    ~(s1_a | s1_b), ~s1_a | ~s1_b, s1_a & s1_b, ~(s1_a & s1_b)};
  assign s1_mask = s1_exp ^ s1_vec_q[7:0];

  assign cur_onehot   = 4'b0001 << {a, b};
  assign acc_next     = 32'(acc_cnt_q) + 32'd1;
  assign complete_cov = accept && ((acc_cov_q | cur_onehot) == 4'hF) && (acc_next >= MIN_VECS);
  assign stop_hit     = STOP_ON_ERR && s1_valid_q && (|s1_mask);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StRun: begin
        in_ready = 1'b1;
        if (complete_cov || stop_hit) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= StRun;
      s1_valid_q <= 1'b0;
      s1_vec_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_vec_q   <= '0;
      s2_mask_q  <= '0;
      acc_cnt_q  <= '0;
      acc_cov_q  <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_vec_q  <= {a, b, dut_out};
        acc_cov_q <= acc_cov_q | cur_onehot;
        if (acc_cnt_q != '1) begin
          acc_cnt_q <= acc_cnt_q + 1'b1;
        end
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_vec_q  <= s1_vec_q;
        s2_mask_q <= s1_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      vec_count_q       <= '0;
      err_count_q       <= '0;
      coverage_q        <= '0;
      first_err_valid_q <= 1'b0;
      first_err_vec_q   <= '0;
      first_err_mask_q  <= '0;
    end else if (s2_valid_q) begin
      if (vec_count_q != '1) begin
        vec_count_q <= vec_count_q + 1'b1;
      end
      coverage_q <= coverage_q | (4'b0001 << s2_vec_q[9:8]);
      if (|s2_mask_q) begin
        if (err_count_q != '1) begin
          err_count_q <= err_count_q + 1'b1;
        end
        if (!first_err_valid_q) begin
          first_err_valid_q <= 1'b1;
          first_err_vec_q   <= s2_vec_q;
          first_err_mask_q  <= s2_mask_q;
        end
      end
    end
  end

  assign vec_count       = vec_count_q;
  assign err_count       = err_count_q;
  assign coverage        = coverage_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_vec   = first_err_vec_q;
  assign first_err_mask  = first_err_mask_q;
  assign pass            = done & (err_count_q == '0);

endmodule

// File: tb/tb_demorgan_checker.sv
// Scoreboard bench for demorgan_checker: three parameterisations share stimulus, one active
// at a time; a monitor pops expected results as each vector reaches the result registers.
module tb_demorgan_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       restart = 1'b0;
  logic       in_valid = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [7:0] dut_out = 8'h00;
  int         sel = 0;

  logic       iv0, iv1, iv2;
  logic       rdy0, rdy1, rdy2;
  logic [7:0] vc0, ec0, vc1, ec1;
  logic [2:0] vc2, ec2;
  logic [3:0] cov0, cov1, cov2;
  logic       fev0, fev1, fev2;
  logic [9:0] fvec0, fvec1, fvec2;
  logic [7:0] fm0, fm1, fm2;
  logic       dn0, dn1, dn2, ps0, ps1, ps2;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  demorgan_checker u_dut (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(iv0), .in_ready(rdy0),
    .a(a), .b(b), .dut_out(dut_out), .vec_count(vc0), .err_count(ec0), .coverage(cov0),
    .first_err_valid(fev0), .first_err_vec(fvec0), .first_err_mask(fm0),
    .done(dn0), .pass(ps0)
  );

  demorgan_checker #(.CNT_W(8), .MIN_VECS(4), .STOP_ON_ERR(1'b1)) u_stop (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(iv1), .in_ready(rdy1),
    .a(a), .b(b), .dut_out(dut_out), .vec_count(vc1), .err_count(ec1), .coverage(cov1),
    .first_err_valid(fev1), .first_err_vec(fvec1), .first_err_mask(fm1),
    .done(dn1), .pass(ps1)
  );

  demorgan_checker #(.CNT_W(3), .MIN_VECS(4), .STOP_ON_ERR(1'b0)) u_sat (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(iv2), .in_ready(rdy2),
    .a(a), .b(b), .dut_out(dut_out), .vec_count(vc2), .err_count(ec2), .coverage(cov2),
    .first_err_valid(fev2), .first_err_vec(fvec2), .first_err_mask(fm2),
    .done(dn2), .pass(ps2)
  );

  logic       r_rdy, r_fev, r_dn, r_ps;
  logic [7:0] r_vc, r_ec, r_fm;
  logic [3:0] r_cov;
  logic [9:0] r_fvec;

  always_comb begin
    {r_rdy, r_vc, r_ec, r_cov, r_fev, r_fvec, r_fm, r_dn, r_ps} =
        {rdy0, vc0, ec0, cov0, fev0, fvec0, fm0, dn0, ps0};
    if (sel == 1) begin
      {r_rdy, r_vc, r_ec, r_cov, r_fev, r_fvec, r_fm, r_dn, r_ps} =
          {rdy1, vc1, ec1, cov1, fev1, fvec1, fm1, dn1, ps1};
    end else if (sel == 2) begin
      {r_rdy, r_vc, r_ec, r_cov, r_fev, r_fvec, r_fm, r_dn, r_ps} =
          {rdy2, 5'b0, vc2, 5'b0, ec2, cov2, fev2, fvec2, fm2, dn2, ps2};
    end
  end

  typedef struct {
    logic [7:0] vc, ec;
    logic [3:0] cov;
    logic       fev;
    logic [9:0] fvec;
    logic [7:0] fm;
    logic       rdy, dn, ps;
    int         tag;
  } exp_t;

  exp_t cnt_q[$];
  exp_t st_q[$];

  // Hand-computed correct responses indexed by {a,b}
  logic [7:0] good [4] = '{8'hED, 8'h95, 8'h55, 8'h12};

  int         m_vc, m_ec, m_max;
  logic [3:0] m_cov;
  logic       m_fev;
  logic [9:0] m_fvec;
  logic [7:0] m_fm;
  int         vec_tag = 0;

  int n_chk = 0;
  int n_fail = 0;

  logic acc_tb = 1'b0;
  logic d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;

  always @(posedge clk) begin
    if (reset || restart) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
      d3 <= 1'b0;
    end else begin
      d1 <= acc_tb;
      d2 <= d1;
      d3 <= d2;
    end
  end

  task automatic cmp(input string nm, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s tag=%0d got %0h expected %0h", nm, tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (d3) begin
      if (cnt_q.size() == 0) begin
        cmp("result_without_vector", 0, 32'(r_vc), 32'hFFFF_FFFF);
      end else begin
        e = cnt_q.pop_front();
        cmp("vec_count", e.tag, 32'(r_vc), 32'(e.vc));
        cmp("err_count", e.tag, 32'(r_ec), 32'(e.ec));
        cmp("coverage", e.tag, 32'(r_cov), 32'(e.cov));
        cmp("first_err_valid", e.tag, 32'(r_fev), 32'(e.fev));
        cmp("first_err_vec", e.tag, 32'(r_fvec), 32'(e.fvec));
        cmp("first_err_mask", e.tag, 32'(r_fm), 32'(e.fm));
      end
    end
    if (st_q.size() != 0) begin
      e = st_q.pop_front();
      cmp("st_vec_count", e.tag, 32'(r_vc), 32'(e.vc));
      cmp("st_err_count", e.tag, 32'(r_ec), 32'(e.ec));
      cmp("st_coverage", e.tag, 32'(r_cov), 32'(e.cov));
      cmp("st_first_err_valid", e.tag, 32'(r_fev), 32'(e.fev));
      cmp("st_first_err_vec", e.tag, 32'(r_fvec), 32'(e.fvec));
      cmp("st_first_err_mask", e.tag, 32'(r_fm), 32'(e.fm));
      cmp("st_in_ready", e.tag, 32'(r_rdy), 32'(e.rdy));
      cmp("st_done", e.tag, 32'(r_dn), 32'(e.dn));
      cmp("st_pass", e.tag, 32'(r_ps), 32'(e.ps));
    end
  end

  function automatic exp_t snap(input int tag, input logic rdy, input logic dn, input logic ps);
    exp_t e;
    e.vc   = m_vc[7:0];
    e.ec   = m_ec[7:0];
    e.cov  = m_cov;
    e.fev  = m_fev;
    e.fvec = m_fvec;
    e.fm   = m_fm;
    e.rdy  = rdy;
    e.dn   = dn;
    e.ps   = ps;
    e.tag  = tag;
    return e;
  endfunction

  task automatic model_reset(input int max);
    m_max  = max;
    m_vc   = 0;
    m_ec   = 0;
    m_cov  = 4'h0;
    m_fev  = 1'b0;
    m_fvec = 10'h0;
    m_fm   = 8'h0;
  endtask

  task automatic model_vec(input logic va, input logic vb, input logic [7:0] out);
    logic [7:0] mask;
    mask = good[{va, vb}] ^ out;
    if (m_vc < m_max) m_vc++;
    m_cov[{va, vb}] = 1'b1;
    if (mask != 8'h00) begin
      if (m_ec < m_max) m_ec++;
      if (!m_fev) begin
        m_fev  = 1'b1;
        m_fvec = {va, vb, out};
        m_fm   = mask;
      end
    end
  endtask

  // Drives a vector until accepted or 20 cycles pass; refusal is legal once draining.
  task automatic send(input logic va, input logic vb, input logic [7:0] out);
    bit ok = 0;
    a        = va;
    b        = vb;
    dut_out  = out;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (r_rdy) begin
        ok     = 1;
        acc_tb = 1'b1;
        model_vec(va, vb, out);
        vec_tag++;
        cnt_q.push_back(snap(vec_tag, 1'b0, 1'b0, 1'b0));
      end
      @(negedge clk);
      acc_tb = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear(input bit use_restart, input int max);
    if (use_restart) restart = 1'b1;
    else reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    cnt_q.delete();
    model_reset(max);
    @(negedge clk);
    reset   = 1'b0;
    restart = 1'b0;
  endtask

  task automatic status(input int tag, input logic rdy, input logic dn, input logic ps);
    idle(6);
    st_q.push_back(snap(tag, rdy, dn, ps));
    idle(2);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && !r_dn; i++) @(negedge clk);
  endtask

  initial begin
    model_reset(255);
    idle(3);
    do_clear(1'b0, 255);
    status(100, 1'b1, 1'b0, 1'b0);

    // All four combinations, correct responses
    send(1'b0, 1'b0, 8'hED);
    send(1'b0, 1'b1, 8'h95);
    send(1'b1, 1'b0, 8'h55);
    send(1'b1, 1'b1, 8'h12);
    wait_done();
    status(101, 1'b0, 1'b1, 1'b1);

    // AorB stuck low on a=1,b=0
    do_clear(1'b0, 255);
    send(1'b1, 1'b0, 8'h45);
    send(1'b0, 1'b0, 8'hED);
    send(1'b0, 1'b1, 8'h95);
    send(1'b1, 1'b1, 8'h12);
    wait_done();
    status(102, 1'b0, 1'b1, 1'b0);

    // Coverage incomplete: done must stay low
    do_clear(1'b0, 255);
    for (int i = 0; i < 10; i++) begin
      send(1'b0, 1'b0, 8'hED);
      send(1'b1, 1'b1, 8'h12);
    end
    status(103, 1'b1, 1'b0, 1'b0);

    // restart and reset with vectors in flight, then a gapped run
    do_clear(1'b0, 255);
    send(1'b0, 1'b0, 8'hED);
    send(1'b0, 1'b1, 8'h95);
    do_clear(1'b1, 255);
    status(104, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 8'h55);
    send(1'b1, 1'b1, 8'h12);
    do_clear(1'b0, 255);
    status(105, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 8'h13);
    idle(2);
    send(1'b1, 1'b0, 8'h55);
    idle(1);
    send(1'b0, 1'b1, 8'h95);
    send(1'b0, 1'b0, 8'hED);
    wait_done();
    status(106, 1'b0, 1'b1, 1'b0);

    // Stop on first error; the fourth vector arrives after draining began
    sel = 1;
    do_clear(1'b0, 255);
    send(1'b0, 1'b0, 8'hED);
    send(1'b0, 1'b1, 8'h94);
    send(1'b0, 1'b0, 8'hED);
    send(1'b1, 1'b1, 8'h12);
    wait_done();
    status(107, 1'b0, 1'b1, 1'b0);
    cmp("stop_vec_count_le3", 107, 32'(r_vc <= 8'd3), 32'd1);

    // 3-bit counters saturate
    sel = 2;
    do_clear(1'b0, 7);
    for (int i = 0; i < 12; i++) send(1'b0, 1'b0, 8'h00);
    status(108, 1'b1, 1'b0, 1'b0);

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
